mavg_sequencer: RTL and testbench

Sequencer and configuration controller that sits in front of the moving-average datapath. It buffers incoming 10-bit samples and issues them to the averager as single-cycle strobes at a programmable sample rate. On any filter-size change it applies the new selection and primes the averager window so stale history is flushed. It captures averager results into a registered output with a valid pulse and a settled flag.

---
 rtl/mavg_sequencer.sv | 153 +++++++++++++++
 tb/tb_mavg_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mavg_sequencer.sv
// Sample sequencer / config controller in front of the moving-average datapath (optional MAVG_SEQ_UNDERRUN_CNT_EN).
// Latency: accepted sample strobed on the next rate tick (>=1 clk); avg_done rise -> result 1 clk later.
// Backpressure: one-entry hold, sample_ready low while hold full unless a RUN tick drains it; ena low freezes all.
module mavg_sequencer #(
    parameter int DATA_W = 10,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [1:0]        filter_select,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_strobe,
    output logic [1:0]        avg_filter_select,
    input  logic [DATA_W-1:0] avg_result,
    input  logic              avg_done,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              settled,
    output logic [7:0]        underrun_cnt
);
    typedef enum logic [1:0] {PRIME = 2'd0, RUN = 2'd1, RECONF = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              started_q;
    logic [DIV_W-1:0]  tick_cnt_q;
    logic              hold_vld;
    logic [DATA_W-1:0] hold_dat, last_dat;
    logic [4:0]        prime_cnt_q, prime_cnt_d;
    logic              prime_lo_q, prime_lo_d;
    logic              done_q, strobe_q, result_vld_q;
    logic              tick, run_tick, consume, accept, sel_change, done_rise;
    logic              prime_strobe, prime_last;

    // started_q keeps the first post-reset edge quiet so the counter can load rate_div there
    assign tick         = started_q && (tick_cnt_q == '0);
    assign run_tick     = tick && (state_q == RUN);
    assign consume      = run_tick && hold_vld;
    assign sel_change   = (filter_select != avg_filter_select);
    assign sample_ready = ena && started_q && (!hold_vld || consume);
    assign accept       = sample_valid && sample_ready;
    assign done_rise    = avg_done && !done_q;
    assign avg_strobe   = strobe_q && ena;
    assign result_valid = result_vld_q && ena;

    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        prime_lo_d   = prime_lo_q;
        prime_strobe = 1'b0;
        prime_last   = 1'b0;
        case (state_q)
            PRIME: begin
                if (started_q) begin
                    if (!prime_lo_q) begin
                        prime_strobe = 1'b1;
                        prime_lo_d   = 1'b1;
                    end else begin
                        // select changes are only honoured at the end of a high/low pair
                        prime_lo_d = 1'b0;
                        if (sel_change) begin
                            state_d = RECONF;
                        end else if (prime_cnt_q == 5'd1) begin
                            state_d    = RUN;
                            prime_last = 1'b1;
                        end else begin
                            prime_cnt_d = prime_cnt_q - 5'd1;
                        end
                    end
                end
            end
            RUN: begin
                if (sel_change) state_d = RECONF;
            end
            RECONF: begin
                state_d     = PRIME;
                prime_cnt_d = 5'd2 << filter_select;
                prime_lo_d  = 1'b0;
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= PRIME;
            started_q         <= 1'b0;
            tick_cnt_q        <= '0;
            hold_vld          <= 1'b0;
            hold_dat          <= '0;
            last_dat          <= '0;
            prime_cnt_q       <= 5'd2;
            prime_lo_q        <= 1'b0;
            done_q            <= 1'b0;
            strobe_q          <= 1'b0;
            result_vld_q      <= 1'b0;
            avg_data          <= '0;
            avg_filter_select <= 2'b00;
            result            <= '0;
            settled           <= 1'b0;
        end else if (ena) begin
            started_q   <= 1'b1;
            tick_cnt_q  <= (!started_q || tick) ? rate_div : tick_cnt_q - DIV_W'(1);
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            prime_lo_q  <= prime_lo_d;
            done_q      <= avg_done;
            strobe_q    <= prime_strobe || run_tick;
            if (prime_strobe || (run_tick && !hold_vld)) begin
                avg_data <= last_dat;
            end else if (consume) begin
                avg_data <= hold_dat;
                last_dat <= hold_dat;
            end
            if (accept) begin
                hold_vld <= 1'b1;
                hold_dat <= sample_in;
            end else if (consume) begin
                hold_vld <= 1'b0;
            end
            if (state_q == RECONF) begin
                avg_filter_select <= filter_select;
                settled           <= 1'b0;
            end else if (prime_last) begin
                settled <= 1'b1;
            end
            // results produced while the window is being re-primed are stale
            result_vld_q <= done_rise && (state_q == RUN);
            if (done_rise && (state_q == RUN)) result <= avg_result;
        end else begin
            strobe_q     <= 1'b0;
            result_vld_q <= 1'b0;
        end
    end

`ifdef MAVG_SEQ_UNDERRUN_CNT_EN
    logic [7:0] underrun_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 8'd0;
        end else if (ena && run_tick && !hold_vld && (underrun_q != 8'hFF)) begin
            underrun_q <= underrun_q + 8'd1;
        end
    end
    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_mavg_sequencer.sv
// Bench for mavg_sequencer: directed phases with randomized data against a cycle-level reference model.
module tb_mavg_sequencer;
    localparam int DATA_W = 10;
    localparam int DIV_W  = 16;
    localparam int M_RUN = 0, M_PRIME = 1, M_RECONF = 2;

    logic              clk, rst_n, ena, sample_valid, sample_ready;
    logic              avg_strobe, avg_done, result_valid, settled;
    logic [DATA_W-1:0] sample_in, avg_data, avg_result, result;
    logic [DIV_W-1:0]  rate_div;
    logic [1:0]        filter_select, avg_filter_select;
    logic [7:0]        underrun_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_started, m_hold_full, m_settled, m_strobe, m_rv, m_prev_done, m_accepted;
    int m_elapsed, m_period, m_mode, m_prime_idx, m_win, m_under;
    int m_hold, m_last, m_data, m_result, m_sel;

    mavg_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .rate_div(rate_div), .filter_select(filter_select),
        .avg_data(avg_data), .avg_strobe(avg_strobe), .avg_filter_select(avg_filter_select),
        .avg_result(avg_result), .avg_done(avg_done),
        .result(result), .result_valid(result_valid), .settled(settled),
        .underrun_cnt(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_hold_full = 0; m_settled = 0; m_strobe = 0; m_rv = 0;
        m_prev_done = 0; m_accepted = 0; m_elapsed = 0; m_period = 0;
        m_mode = M_PRIME; m_prime_idx = 0; m_win = 2; m_under = 0;
        m_hold = 0; m_last = 0; m_data = 0; m_result = 0; m_sel = 0;
    endtask

    function automatic bit m_tick();
        return m_started && (m_elapsed == m_period);
    endfunction

    function automatic bit m_ready();
        return ena && m_started && (!m_hold_full || (m_mode == M_RUN && m_tick()));
    endfunction

    // one clock edge of the specified behaviour
    task automatic model_step();
        bit tk, acc, old_full;
        int old_mode, old_hold;
        m_accepted = 0;
        if (!ena) begin
            m_strobe = 0;
            m_rv = 0;
            return;
        end
        tk = m_tick();
        acc = sample_valid && m_ready();
        old_mode = m_mode; old_hold = m_hold; old_full = m_hold_full;
        m_strobe = 0;
        if (old_mode == M_RUN) begin
            if (tk) begin
                m_strobe = 1;
                if (old_full) begin
                    m_data = old_hold; m_last = old_hold; m_hold_full = 0;
                end else begin
                    m_data = m_last;
`ifdef MAVG_SEQ_UNDERRUN_CNT_EN
                    if (m_under < 255) m_under++;
`endif
                end
            end
            if (int'(filter_select) != m_sel) m_mode = M_RECONF;
        end else if (old_mode == M_PRIME) begin
            if (m_started) begin
                if (m_prime_idx % 2 == 0) begin
                    m_strobe = 1; m_data = m_last; m_prime_idx++;
                end else if (int'(filter_select) != m_sel) begin
                    m_mode = M_RECONF;
                end else if (m_prime_idx == 2 * m_win - 1) begin
                    m_mode = M_RUN; m_settled = 1;
                end else begin
                    m_prime_idx++;
                end
            end
        end else begin
            m_sel = int'(filter_select); m_settled = 0;
            m_win = 2 << filter_select; m_prime_idx = 0; m_mode = M_PRIME;
        end
        if (acc) begin
            m_hold = int'(sample_in); m_hold_full = 1; m_accepted = 1;
        end
        m_rv = avg_done && !m_prev_done && (old_mode == M_RUN);
        if (m_rv) m_result = int'(avg_result);
        m_prev_done = avg_done;
        if (!m_started || tk) begin
            m_period = int'(rate_div); m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
        m_started = 1;
    endtask

    task automatic cycle();
        #1;
        check("sample_ready", sample_ready, m_ready());
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check("avg_strobe", avg_strobe, m_strobe);
        check("avg_data", avg_data, m_data);
        check("avg_filter_select", avg_filter_select, m_sel);
        check("result", result, m_result);
        check("result_valid", result_valid, m_rv);
        check("settled", settled, m_settled);
        check("underrun_cnt", underrun_cnt, m_under);
    endtask

    task automatic rand_cycle();
        avg_done = 1'($urandom_range(0, 1));
        avg_result = DATA_W'($urandom_range(0, 1023));
        cycle();
        if (m_accepted) sample_in = DATA_W'($urandom_range(0, 1023));
    endtask

    task automatic check_reset();
        check("rst_avg_data", avg_data, 0);
        check("rst_avg_strobe", avg_strobe, 0);
        check("rst_avg_filter_select", avg_filter_select, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_settled", settled, 0);
        check("rst_sample_ready", sample_ready, 0);
        check("rst_underrun_cnt", underrun_cnt, 0);
    endtask

    task automatic startup_pattern();
        bit exp_strb[5] = '{0, 1, 0, 1, 0};
        bit exp_setl[5] = '{0, 0, 0, 0, 1};
        for (int c = 0; c < 5; c++) begin
            cycle();
            check($sformatf("start_strobe_c%0d", c), avg_strobe, exp_strb[c]);
            check($sformatf("start_settled_c%0d", c), settled, exp_setl[c]);
        end
    endtask

    initial begin
        int k, cnt, setl_cnt, last_strb, cyc;
        rst_n = 1'b1; ena = 1'b1; sample_in = '0; sample_valid = 1'b0;
        rate_div = '0; filter_select = 2'b00; avg_result = '0; avg_done = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        // phase 1: no samples, rate_div=0 -> priming then per-cycle underrun strobes
        startup_pattern();
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("underrun_strobe_every_cycle", avg_strobe, 1);
        end

        // phase 2: rate_div=24, continuous samples 0, 1023, random...
        rate_div = 16'd24; sample_valid = 1'b1; sample_in = '0; k = 0;
        last_strb = -1;
        for (int i = 0; i < 200; i++) begin
            avg_done = 1'($urandom_range(0, 1));
            avg_result = DATA_W'($urandom_range(0, 1023));
            cycle();
            if (avg_strobe) begin
                if (last_strb >= 0) check("strobe_spacing_25", i - last_strb, 25);
                last_strb = i;
            end
            if (m_accepted) begin
                k++;
                sample_in = (k == 1) ? 10'd1023 : DATA_W'($urandom_range(0, 1023));
            end
        end

        // phase 3: 00 -> 10 from RUN
        filter_select = 2'b10;
        rand_cycle();
        rand_cycle();
        check("sel_applied_10", avg_filter_select, 2'b10);
        check("settled_drop_10", settled, 0);
        cnt = 0; setl_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            rand_cycle();
            if (avg_strobe) cnt++;
            if (i < 15 && settled) setl_cnt++;
        end
        check("prime8_strobes", cnt, 8);
        check("prime8_settled_low", setl_cnt, 0);
        check("prime8_settled_end", settled, 1);

        // phase 4: restart priming at the 3rd strobe of an 8-window
        filter_select = 2'b00;
        for (int i = 0; i < 12; i++) rand_cycle();
        filter_select = 2'b10;
        for (int i = 0; i < 7; i++) rand_cycle();
        check("third_prime_strobe", avg_strobe, 1);
        filter_select = 2'b11;
        cnt = 0;
        for (int i = 0; i < 33; i++) begin
            rand_cycle();
            if (avg_strobe) cnt++;
        end
        check("prime16_strobes", cnt, 16);
        check("prime16_settled_before", settled, 0);
        rand_cycle();
        check("prime16_settled_after", settled, 1);
        check("sel_applied_11", avg_filter_select, 2'b11);

        // phase 5: starve at rate_div=3 for >300 ticks
        rate_div = 16'd3; sample_valid = 1'b0;
        for (int i = 0; i < 1210; i++) rand_cycle();
`ifdef MAVG_SEQ_UNDERRUN_CNT_EN
        check("underrun_saturated", underrun_cnt, 255);
`else
        check("underrun_tied_zero", underrun_cnt, 0);
`endif

        // phase 6: ena low for 10 cycles mid-RUN
        rate_div = 16'd5; sample_valid = 1'b1;
        for (int i = 0; i < 30; i++) rand_cycle();
        ena = 1'b0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rand_cycle();
            if (avg_strobe || result_valid) cnt++;
        end
        check("ena_low_quiet", cnt, 0);
        ena = 1'b1;
        for (int i = 0; i < 30; i++) rand_cycle();

        // phase 7: randomized mix
        for (cyc = 0; cyc < 1500; cyc++) begin
            ena = ($urandom_range(0, 9) != 0);
            sample_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) filter_select = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) rate_div = DIV_W'($urandom_range(0, 6));
            rand_cycle();
        end

        // phase 8: asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        ena = 1'b1; filter_select = 2'b00; sample_valid = 1'b0; avg_done = 1'b0;
        rate_div = 16'd2;
        rst_n = 1'b1;
        startup_pattern();
        sample_valid = 1'b1;
        for (int i = 0; i < 40; i++) rand_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
